// File: rtl/test_access_port.sv
// Test/debug port responder: arbitrates host memory/register accesses,
// hands the memory and register-file ports to the CPU in run mode, drives
// CPU reset/PC preload and counts instruction fetches while running.
module test_access_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              test,
  input  logic              memoryoperation,
  input  logic              registeroperation,
  input  logic              memorywrite,
  input  logic              registerwrite,
  input  logic [ADDR_W-1:0] memaddress,
  input  logic [DATA_W-1:0] memwritedata,
  input  logic [REG_AW-1:0] registeraddress,
  input  logic [DATA_W-1:0] regwritedata,
  input  logic [ADDR_W-1:0] resetpc,
  output logic [DATA_W-1:0] MD,
  output logic [DATA_W-1:0] RD,
  output logic              cpu_en,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  input  logic              cpu_fetch,
  output logic [15:0]       fetch_count,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_wdata,
  input  logic              cpu_mem_we,
  input  logic [REG_AW-1:0] cpu_rf_addr,
  input  logic [DATA_W-1:0] cpu_rf_wdata,
  input  logic              cpu_rf_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_M_ISSUE,
    S_M_CAP,
    S_R_ISSUE,
    S_R_CAP
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] md_q, md_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [15:0]       fc_q, fc_d;

  logic md_load, rd_load, fc_clear, fc_inc;

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: run request beats host requests in IDLE, memory beats
  // register; an access only ends once its request level drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (test)                   state_d = S_RUN;
        else if (memoryoperation)   state_d = S_M_ISSUE;
        else if (registeroperation) state_d = S_R_ISSUE;
      end
      S_RUN:     if (!test) state_d = S_IDLE;
      S_M_ISSUE: state_d = S_M_CAP;
      S_M_CAP:   if (!memoryoperation) state_d = S_IDLE;
      S_R_ISSUE: state_d = S_R_CAP;
      S_R_CAP:   if (!registeroperation) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Port ownership and control strobes; write enables only in the single
  // ISSUE cycle, so a held request can never write twice.
  always_comb begin
    cpu_en    = 1'b0;
    mem_addr  = memaddress;
    mem_wdata = memwritedata;
    mem_we    = 1'b0;
    rf_addr   = registeraddress;
    rf_wdata  = regwritedata;
    rf_we     = 1'b0;
    md_load   = 1'b0;
    rd_load   = 1'b0;
    fc_clear  = 1'b0;
    fc_inc    = 1'b0;
    case (state_q)
      S_IDLE: fc_clear = test;
      S_RUN: begin
        cpu_en    = 1'b1;
        mem_addr  = cpu_mem_addr;
        mem_wdata = cpu_mem_wdata;
        mem_we    = cpu_mem_we;
        rf_addr   = cpu_rf_addr;
        rf_wdata  = cpu_rf_wdata;
        rf_we     = cpu_rf_we;
        fc_inc    = cpu_fetch;
      end
      S_M_ISSUE: mem_we  = memorywrite;
      S_M_CAP:   md_load = 1'b1;
      S_R_ISSUE: rf_we   = registerwrite;
      S_R_CAP:   rd_load = 1'b1;
      default: ;
    endcase
  end

  // Read-back and fetch counter next values; counter saturates at all-ones.
  always_comb begin
    md_d = md_load ? mem_rdata : md_q;
    rd_d = rd_load ? rf_rdata : rd_q;
    fc_d = fc_q;
    if (fc_clear)                  fc_d = '0;
    else if (fc_inc && fc_q != '1) fc_d = fc_q + 16'd1;
  end

  // Read-back and fetch counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_q <= '0;
      rd_q <= '0;
      fc_q <= '0;
    end else begin
      md_q <= md_d;
      rd_q <= rd_d;
      fc_q <= fc_d;
    end
  end

  assign MD          = md_q;
  assign RD          = rd_q;
  assign fetch_count = fc_q;
  assign pc_load     = reset;
  assign pc_value    = resetpc;

endmodule

// File: tb/tb_test_access_port.sv
module tb_test_access_port;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, test, memoryoperation, registeroperation;
  logic          memorywrite, registerwrite;
  logic [AW-1:0] memaddress, resetpc, cpu_mem_addr;
  logic [DW-1:0] memwritedata, regwritedata, cpu_mem_wdata, cpu_rf_wdata;
  logic [RW-1:0] registeraddress, cpu_rf_addr;
  logic          cpu_fetch, cpu_mem_we, cpu_rf_we;
  logic [DW-1:0] MD, RD;
  logic          cpu_en, pc_load;
  logic [AW-1:0] pc_value, mem_addr;
  logic [15:0]   fetch_count;
  logic [DW-1:0] mem_wdata, rf_wdata, rf_rdata;
  logic          mem_we, rf_we;
  logic [RW-1:0] rf_addr;
  logic [DW-1:0] mem_rdata = '0;

  test_access_port #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW)) dut (
    .clk(clk), .reset(reset), .test(test),
    .memoryoperation(memoryoperation), .registeroperation(registeroperation),
    .memorywrite(memorywrite), .registerwrite(registerwrite),
    .memaddress(memaddress), .memwritedata(memwritedata),
    .registeraddress(registeraddress), .regwritedata(regwritedata),
    .resetpc(resetpc), .MD(MD), .RD(RD), .cpu_en(cpu_en),
    .pc_load(pc_load), .pc_value(pc_value), .cpu_fetch(cpu_fetch),
    .fetch_count(fetch_count),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_we(cpu_mem_we),
    .cpu_rf_addr(cpu_rf_addr), .cpu_rf_wdata(cpu_rf_wdata), .cpu_rf_we(cpu_rf_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
  );

  // External memory (sync read, write-first) and register file (comb read)
  logic [15:0] tb_mem [16] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005,
                               16'h1006, 16'h1007, 16'h1008, 16'h1009, 16'h100A, 16'h100B,
                               16'h100C, 16'h100D, 16'h100E, 16'h100F};
  logic [15:0] tb_rf  [16] = '{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005,
                               16'h2006, 16'h2007, 16'h2008, 16'h2009, 16'h200A, 16'h200B,
                               16'h200C, 16'h200D, 16'h200E, 16'h200F};
  int mem_we_pulses = 0;
  int rf_we_pulses  = 0;

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[3:0]] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : tb_mem[mem_addr[3:0]];
    if (rf_we) tb_rf[rf_addr] <= rf_wdata;
    if (mem_we) mem_we_pulses <= mem_we_pulses + 1;
    if (rf_we)  rf_we_pulses  <= rf_we_pulses + 1;
  end
  assign rf_rdata = tb_rf[rf_addr];

  // Reference model: ownership flag, access phase per port, shadow storage
  bit          m_run;
  int          m_mph;  // -1 none, 0 address cycle, 1 capture cycles
  int          m_rph;
  logic [15:0] m_md, m_rd, m_fc, m_lat;
  logic [15:0] ref_mem [16];
  logic [15:0] ref_rf  [16];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic own, emwe, erwe;
    own  = m_run && !reset;
    emwe = !reset && (own ? cpu_mem_we : (m_mph == 0 && memorywrite));
    erwe = !reset && (own ? cpu_rf_we  : (m_rph == 0 && registerwrite));
    chk("mem_we", {31'd0, mem_we}, {31'd0, emwe});
    chk("rf_we",  {31'd0, rf_we},  {31'd0, erwe});
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, own ? cpu_mem_addr : memaddress});
    chk("rf_addr",  {28'd0, rf_addr},  {28'd0, own ? cpu_rf_addr : registeraddress});
    if (emwe) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, own ? cpu_mem_wdata : memwritedata});
    if (erwe) chk("rf_wdata",  {16'd0, rf_wdata},  {16'd0, own ? cpu_rf_wdata : regwritedata});
    if (reset) begin
      chk("cpu_en_rst", {31'd0, cpu_en}, 0);
      chk("MD_rst", {16'd0, MD}, 0);
      chk("RD_rst", {16'd0, RD}, 0);
      chk("fetch_count_rst", {16'd0, fetch_count}, 0);
      chk("pc_load_rst", {31'd0, pc_load}, 1);
      chk("pc_value_rst", {16'd0, pc_value}, {16'd0, resetpc});
    end else begin
      chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_run});
      chk("MD", {16'd0, MD}, {16'd0, m_md});
      chk("RD", {16'd0, RD}, {16'd0, m_rd});
      chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_fc});
      chk("pc_load", {31'd0, pc_load}, 0);
    end
  endtask

  task automatic advance();
    logic own, mwe, rwe;
    logic [3:0] ma, ra;
    own = m_run && !reset;
    ma  = own ? cpu_mem_addr[3:0] : memaddress[3:0];
    ra  = own ? cpu_rf_addr : registeraddress;
    mwe = !reset && (own ? cpu_mem_we : (m_mph == 0 && memorywrite));
    rwe = !reset && (own ? cpu_rf_we  : (m_rph == 0 && registerwrite));
    if (reset) begin
      m_run = 0; m_mph = -1; m_rph = -1; m_md = '0; m_rd = '0; m_fc = '0;
    end else if (m_run) begin
      if (cpu_fetch && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (!test) m_run = 0;
    end else if (m_mph == 0) m_mph = 1;
    else if (m_mph == 1) begin
      m_md = m_lat;
      if (!memoryoperation) m_mph = -1;
    end else if (m_rph == 0) m_rph = 1;
    else if (m_rph == 1) begin
      m_rd = ref_rf[registeraddress];
      if (!registeroperation) m_rph = -1;
    end else if (test) begin
      m_run = 1; m_fc = '0;
    end else if (memoryoperation) m_mph = 0;
    else if (registeroperation) m_rph = 0;
    if (mwe) ref_mem[ma] = own ? cpu_mem_wdata : memwritedata;
    m_lat = ref_mem[ma];
    if (rwe) ref_rf[ra] = own ? cpu_rf_wdata : regwritedata;
  endtask

  // Called at a falling edge with inputs set; checks, steps model, waits
  task automatic tick();
    #1;
    compare();
    advance();
    @(negedge clk);
  endtask

  int base_m, base_r;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'h1000 + 16'(i);
      ref_rf[i]  = 16'h2000 + 16'(i);
    end
    m_run = 0; m_mph = -1; m_rph = -1;
    m_md = '0; m_rd = '0; m_fc = '0; m_lat = '0;
    reset = 1; test = 0; memoryoperation = 0; registeroperation = 0;
    memorywrite = 0; registerwrite = 0; memaddress = '0; memwritedata = '0;
    registeraddress = '0; regwritedata = '0; resetpc = 16'h0001;
    cpu_fetch = 0; cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_mem_we = 0;
    cpu_rf_addr = '0; cpu_rf_wdata = '0; cpu_rf_we = 0;

    @(negedge clk);
    tick();
    chk("lit_pc_load", {31'd0, pc_load}, 1);
    chk("lit_pc_value", {16'd0, pc_value}, 32'h0001);
    chk("lit_cpu_en_rst", {31'd0, cpu_en}, 0);
    reset = 0;
    tick();

    // Memory write held across cycles: one pulse, MD valid two edges later
    base_m = mem_we_pulses;
    memaddress = 16'd1; memwritedata = 16'hAE07; memorywrite = 1; memoryoperation = 1;
    tick(); tick();
    chk("lit_md_not_yet", {16'd0, MD}, 0);
    tick();
    chk("lit_md_write", {16'd0, MD}, 32'hAE07);
    memoryoperation = 0; memorywrite = 0;
    tick();
    chk("lit_mem_one_pulse", mem_we_pulses - base_m, 1);

    // Register write
    base_r = rf_we_pulses;
    registeraddress = 4'd0; regwritedata = 16'd11; registerwrite = 1; registeroperation = 1;
    tick(); tick(); tick(); tick();
    chk("lit_rd_write", {16'd0, RD}, 32'h000B);
    registeroperation = 0; registerwrite = 0;
    tick();
    chk("lit_rf_one_pulse", rf_we_pulses - base_r, 1);

    // Run with host memory write request held: host must never write
    base_m = mem_we_pulses;
    test = 1; memoryoperation = 1; memorywrite = 1; memaddress = 16'd3; memwritedata = 16'hDEAD;
    tick();
    chk("lit_cpu_en_run", {31'd0, cpu_en}, 1);
    cpu_rf_we = 1; cpu_rf_addr = 4'd6; cpu_rf_wdata = 16'h5A5A;
    tick();
    cpu_rf_we = 0;
    for (int i = 0; i < 31; i++) begin
      cpu_fetch = 1; tick();
      cpu_fetch = 0; tick();
    end
    chk("lit_fetch_31", {16'd0, fetch_count}, 31);
    chk("lit_isolation", mem_we_pulses - base_m, 0);
    cpu_mem_we = 1; cpu_mem_addr = 16'd4; cpu_mem_wdata = 16'h7777;
    tick();
    cpu_mem_we = 0;
    chk("lit_cpu_write_pulse", mem_we_pulses - base_m, 1);
    chk("lit_cpu_write_data", {16'd0, tb_mem[4]}, 32'h7777);
    chk("lit_host_not_written", {16'd0, tb_mem[3]}, 32'h1003);
    memoryoperation = 0; memorywrite = 0; test = 0;
    tick();
    chk("lit_cpu_en_drop", {31'd0, cpu_en}, 0);
    cpu_fetch = 1;
    tick();
    cpu_fetch = 0;
    chk("lit_fetch_held", {16'd0, fetch_count}, 31);

    // Read register written by the CPU
    registeroperation = 1; registerwrite = 0; registeraddress = 4'd6;
    tick(); tick(); tick();
    chk("lit_rd_reg6", {16'd0, RD}, 32'h5A5A);
    registeroperation = 0;
    tick();

    // Arbitration: memory first, register waits for memoryoperation to drop
    base_r = rf_we_pulses;
    memoryoperation = 1; memorywrite = 0; memaddress = 16'd5;
    registeroperation = 1; registerwrite = 1; registeraddress = 4'd9; regwritedata = 16'h0909;
    repeat (4) tick();
    chk("lit_arb_reg_waits", rf_we_pulses - base_r, 0);
    chk("lit_arb_md", {16'd0, MD}, 32'h1005);
    memoryoperation = 0;
    tick(); tick();
    chk("lit_arb_no_pulse_yet", rf_we_pulses - base_r, 0);
    tick(); tick();
    chk("lit_arb_rd", {16'd0, RD}, 32'h0909);
    tick(); tick();
    chk("lit_arb_held_no_rewrite", rf_we_pulses - base_r, 1);
    registeroperation = 0; registerwrite = 0;
    tick();

    // Async reset during a memory write address cycle
    base_m = mem_we_pulses;
    memoryoperation = 1; memorywrite = 1; memaddress = 16'd2; memwritedata = 16'hBEEF;
    tick();
    #1;
    chk("lit_issue_we", {31'd0, mem_we}, 1);
    reset = 1;
    #1;
    chk("lit_async_we", {31'd0, mem_we}, 0);
    chk("lit_async_md", {16'd0, MD}, 0);
    chk("lit_async_pc_load", {31'd0, pc_load}, 1);
    tick();
    reset = 0; memoryoperation = 0; memorywrite = 0;
    tick(); tick();
    chk("lit_abort_no_pulse", mem_we_pulses - base_m, 0);
    chk("lit_abort_mem", {16'd0, tb_mem[2]}, 32'h1002);

    // Randomized traffic
    repeat (2000) begin
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(15) == 0) test = ~test;
      if ($urandom_range(3) == 0) memoryoperation = ~memoryoperation;
      if ($urandom_range(3) == 0) registeroperation = ~registeroperation;
      memorywrite     = 1'($urandom);
      registerwrite   = 1'($urandom);
      if ($urandom_range(2) == 0) memaddress = 16'($urandom_range(15));
      memwritedata    = 16'($urandom);
      if ($urandom_range(2) == 0) registeraddress = 4'($urandom);
      regwritedata    = 16'($urandom);
      resetpc         = 16'($urandom);
      cpu_fetch       = 1'($urandom);
      cpu_mem_addr    = 16'($urandom_range(15));
      cpu_mem_wdata   = 16'($urandom);
      cpu_mem_we      = 1'($urandom);
      cpu_rf_addr     = 4'($urandom);
      cpu_rf_wdata    = 16'($urandom);
      cpu_rf_we       = 1'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test_access_port.md
Name: test_access_port

Overview:
- Responder side of the CPU test/debug port. Serves host-initiated memory and register reads/writes, owns CPU reset and PC preload, and gates CPU execution.
- Sits inside the system wrapper, between the external test-port pins and the CPU datapath.
- Muxes the main memory and register-file ports between the CPU (run mode) and the host (test mode).
- Counts instruction fetches while the CPU runs.

Parameters:
- DATA_W, 16, memory/register data width
- ADDR_W, 16, memory address width
- REG_AW, 4, register-file address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- test  in  1  1 = CPU runs and owns memory/regfile; 0 = host access allowed
- memoryoperation  in  1  host memory request, level
- registeroperation  in  1  host register request, level
- memorywrite  in  1  memory request is a write
- registerwrite  in  1  register request is a write
- memaddress  in  ADDR_W  host memory address
- memwritedata  in  DATA_W  host memory write data
- registeraddress  in  REG_AW  host register address
- regwritedata  in  DATA_W  host register write data
- resetpc  in  ADDR_W  PC value loaded while reset is high
- MD  out  DATA_W  memory read-back
- RD  out  DATA_W  register read-back
- cpu_en  out  1  CPU clock-enable
- pc_load  out  1  force PC := pc_value
- pc_value  out  ADDR_W  PC preload value
- cpu_fetch  in  1  CPU is in fetch state (state==1); one pulse per instruction
- fetch_count  out  16  fetches since run start, saturating
- cpu_mem_addr / cpu_mem_wdata / cpu_mem_we  in  ADDR_W/DATA_W/1  CPU memory request
- cpu_rf_addr / cpu_rf_wdata / cpu_rf_we  in  REG_AW/DATA_W/1  CPU register-file request
- mem_addr / mem_wdata / mem_we  out  ADDR_W/DATA_W/1  to memory
- mem_rdata  in  DATA_W  memory read data, synchronous, 1-cycle latency
- rf_addr / rf_wdata / rf_we  out  REG_AW/DATA_W/1  to register file
- rf_rdata  in  DATA_W  register-file read data, combinational

Behaviour:
- Reset (async, high):
  - state=IDLE; MD=0; RD=0; fetch_count=0; cpu_en=0; mem_we=0; rf_we=0.
  - pc_load=1 and pc_value=resetpc continuously while reset is high.
- States:
  - IDLE: no access in progress.
  - RUN: CPU executing.
  - M_ISSUE, M_CAP: memory access.
  - R_ISSUE, R_CAP: register access.
- Mode and ownership:
  - test=1 in IDLE -> RUN next edge.
  - In RUN: cpu_en=1; memory/regfile ports pass cpu_* through unregistered; host requests ignored.
  - test=0 in RUN -> IDLE next edge; cpu_en=0 from that edge.
  - Any non-RUN state: cpu_en=0; host owns ports; cpu_*_we blocked.
- Request arbitration (IDLE, test=0):
  - memoryoperation=1 -> M_ISSUE.
  - else registeroperation=1 -> R_ISSUE.
  - Both asserted: memory wins; register request waits until memoryoperation drops.
- M_ISSUE (1 cycle):
  - mem_addr=memaddress.
  - mem_we=memorywrite, mem_wdata=memwritedata.
  - Write is a single-cycle we pulse.
- M_CAP:
  - mem_addr held; mem_we=0; MD<=mem_rdata on exit edge.
  - After a write, this returns the written value.
  - MD is valid two posedges after request sampled.
  - Stays in M_CAP while memoryoperation=1, refreshing MD every cycle (tracks address changes with 1-cycle lag).
  - Returns to IDLE when memoryoperation=0.
- R_ISSUE / R_CAP: same structure for the register file.
  - rf_we pulses one cycle on R_ISSUE.
  - RD<=rf_rdata every R_CAP cycle.
  - A held registerwrite does NOT re-write.
  - A new write needs the operation dropped and reasserted.
- Write pulse rule: at most one mem_we/rf_we pulse per request assertion, regardless of how long the request is held.
- fetch_count:
  - Cleared on the IDLE->RUN edge.
  - +1 per cycle with cpu_fetch=1 in RUN.
  - Saturates at 16'hFFFF.
  - Held (readable) in all other states.
- Host reset / PC preload:
  - reset mid-access aborts immediately: no further we pulses; MD/RD return to 0.
  - pc_load is 0 whenever reset=0.
- test rising during M_*/R_*: current access completes (through CAP exit), then IDLE->RUN.

Test Plan:
- Mem write: memaddress=1, memwritedata=16'hAE07, memorywrite=1 for 2 cycles -> exactly one mem_we pulse; MD=16'hAE07 at 2nd posedge.
- Reg write/read: registeraddress=0, regwritedata=11 -> one rf_we; RD=16'h000B; then read reg 6 after run -> RD equals rf_rdata[6].
- Run: reset with resetpc=1 -> pc_load=1, pc_value=1; test=1, 31 cpu_fetch pulses -> fetch_count=31; cpu_en drops one edge after test=0.
- Arbitration: memoryoperation and registeroperation both asserted -> memory served first; register access starts only after memoryoperation drops.
- Isolation: test=1 with memorywrite asserted -> mem_we follows cpu_mem_we only; host data never written.
- Async reset mid M_ISSUE (write) -> mem_we deasserts without a clock edge; MD=0; state IDLE; memory untouched by a second pulse.
